// File: rtl/seq_divider32.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seq_divider32
// Brief    : Multi-cycle unsigned restoring divider (DIV/REM execution unit).
//            One shift-subtract iteration per clock, MSB first, with a
//            valid/ready handshake on both the operand and result sides.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    // Iteration counter must be able to hold the value WIDTH itself.
    localparam int              c_CW   = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_rem;        // partial remainder
    logic [WIDTH-1:0] r_q;          // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] r_div;        // latched divisor
    logic [c_CW-1:0]  r_count;      // completed iterations
    logic             r_dbz;        // latched divide-by-zero flag

    logic             w_accept;
    logic             w_finish;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;

    // Handshake qualifiers derived from the current state.
    always_comb begin
        w_accept = 1'b0;
        w_finish = 1'b0;
        w_accept = in_valid && (r_state == S_IDLE);
        w_finish = (r_state == S_RUN) && (r_count == c_LAST);
    end

    // One restoring step: shift in the next dividend bit, trial-subtract.
    always_comb begin
        w_shifted = '0;
        w_diff    = '0;
        w_borrow  = 1'b0;
        w_shifted = {r_rem, r_q[WIDTH-1]};
        w_diff    = w_shifted - {1'b0, r_div};
        w_borrow  = w_diff[WIDTH];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_count == c_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, iterations, and result publication on entry to DONE.
    // A zero divisor preloads the final answer and jumps the counter straight to
    // its last value, so the result appears one cycle after accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem       <= '0;
            r_q         <= '0;
            r_div       <= '0;
            r_count     <= '0;
            r_dbz       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (w_accept) begin
            r_div <= divisor;
            if (divisor == '0) begin
                r_q     <= '1;
                r_rem   <= dividend;
                r_count <= c_LAST;
                r_dbz   <= 1'b1;
            end else begin
                r_q     <= dividend;
                r_rem   <= '0;
                r_count <= '0;
                r_dbz   <= 1'b0;
            end
        end else if (w_finish) begin
            quotient    <= r_q;
            remainder   <= r_rem;
            div_by_zero <= r_dbz;
        end else if (r_state == S_RUN) begin
            r_count <= r_count + 1'b1;
            if (!w_borrow) begin
                r_rem <= w_diff[WIDTH-1:0];
                r_q   <= {r_q[WIDTH-2:0], 1'b1};
            end else begin
                r_rem <= w_shifted[WIDTH-1:0];
                r_q   <= {r_q[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule
`default_nettype wire
